snoop_responder: RTL and testbench
==================================

# snoop_responder

Per-dcache coherence responder: the cache-side end of the snoop protocol driven by the memory controller. It watches `ccwait`/`ccsnoopaddr`/`ccinv` and looks up the addressed block in its dcache's tag/state arrays. On a hit to a dirty (M) line it writes the two-word block back through the dcache's memory port while holding `cctrans`, so the requester receives the data. It then demotes the line to S, or to I on an invalidating snoop. One instance sits inside each core's dcache, between the cache arrays and the cache-control interface.

## Interface
- `SETS`, 8, number of sets; power of two; `IDX_W = log2(SETS)`.
- `WAYS`, 2, associativity; `TAG_W = 32 - IDX_W - 3` (1 block-offset bit, 2 byte-offset bits).
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ccwait`  in  1  snoop request from the memory controller.
- `ccinv`  in  1  snoop is invalidating (requester intends to write); valid with `ccwait`.
- `ccsnoopaddr`  in  32  snooped byte address.
- `dwait`  in  1  memory-port wait from the controller; low = current write word accepted.
- `cctrans`  out  1  responder busy / transition in progress.
- `snp_active`  out  1  responder owns the dcache memory port and state write port; the dcache stalls its own traffic.
- `snp_dWEN`  out  1  write-back request; muxed onto the cache's `dWEN` while `snp_active`.
- `snp_daddr`  out  32  write-back word address.
- `snp_dstore`  out  32  write-back data.
- `tag_rd_idx`  out  IDX_W  set index to the arrays; always `ccsnoopaddr[IDX_W+2:3]`.
- `way_tag`  in  WAYS*TAG_W  tags of the indexed set (asynchronous read).
- `way_valid`, `way_dirty`  in  WAYS each  state bits of the indexed set.
- `way_data0`, `way_data1`  in  WAYS*32 each  block words 0 and 1 of the indexed set.
- `st_wen`  out  1  state write strobe; it has priority over the dcache's own state writes.
- `st_idx`  out  IDX_W, `st_way`  out  log2(WAYS), `st_valid`  out  1, `st_dirty`  out  1  state write payload.

## Operation
- **Hit detection:** way w hits when `way_valid[w]` and `way_tag[w] == ccsnoopaddr[31:IDX_W+3]`. If two ways hit, the lowest index wins.
- **Capture:** in IDLE with `ccwait=1`, the block captures the following into registers: hit flag, hit way, dirty bit, tag, index, both data words, and `ccinv`.
- **FSM:** IDLE, WB0, WB1, UPDATE, DONE.
  - IDLE, `ccwait=1`:
    - hit and dirty -> WB0
    - hit, clean, `ccinv` -> UPDATE
    - otherwise (miss, or clean hit without `ccinv`) -> DONE
  - IDLE, `ccwait=0`: stay in IDLE.
  - WB0: `snp_dWEN=1`, `snp_daddr={tag,idx,1'b0,2'b00}`, `snp_dstore`=word0. Leave to WB1 on `dwait=0`; otherwise stay.
  - WB1: same with block-offset bit 1 and word1. Leave to UPDATE on `dwait=0`.
  - UPDATE: `st_wen=1` with captured idx/way. Payload is `st_valid=~inv`, `st_dirty=0`, i.e. M->S, or M/S->I when `ccinv`. Then -> DONE.
  - DONE: wait for `ccwait=0`, then -> IDLE. A new snoop is never accepted in DONE.
- **`cctrans`:** 1 in (IDLE and `ccwait`), WB0, WB1 and UPDATE; 0 in DONE and in idle IDLE.
  - Asserting it combinationally in the first `ccwait` cycle keeps the controller in SNOOP until the responder has decided.
- **`snp_active`:** 1 whenever `cctrans`=1 or state is DONE.
- **Default outputs:** `snp_dWEN`, `snp_daddr`, `snp_dstore`, `st_*` are 0 outside WB0/WB1/UPDATE.
- **Unaffected cases:** a miss, or a clean hit without `ccinv`, produces no write-back and no state write.

## Timing
- **Reset:** `RST` high at a clock edge forces IDLE and clears all captured registers. It takes effect in any state, including mid-write-back, and no state write is issued.
  - Reset values: `cctrans=0`, `snp_active=0`, `snp_dWEN=0`, `snp_daddr=0`, `snp_dstore=0`, `st_wen=0`, `st_idx=0`, `st_way=0`, `st_valid=0`, `st_dirty=0`. (`tag_rd_idx` tracks `ccsnoopaddr`.)
- **Latency:**
  - Miss or unaffected line: `cctrans` high for exactly 1 cycle.
  - Clean invalidate: `cctrans` high for 2 cycles.
  - Dirty hit: `cctrans` high for 1 + (WB0 cycles) + (WB1 cycles) + 1 cycles; minimum 4 when `dwait` is low immediately.
- **Write-back handshake:** `snp_dWEN`, `snp_daddr` and `snp_dstore` are held stable while `dwait=1`. A word is complete on the edge where `dwait=0`.
- **Stale inputs:** the responder ignores `ccsnoopaddr`/`ccinv` changes after the capture cycle, and ignores the array inputs after the capture cycle.
- **Back-to-back snoops:** `ccwait` held high through DONE is treated as the same snoop. A new snoop needs `ccwait` low for at least 1 cycle.

## Test plan
- **Miss:** `ccwait=1`, `ccsnoopaddr=0x0000_0040`, no valid tags -> `cctrans` high 1 cycle, no `snp_dWEN`, no `st_wen`; DONE until `ccwait` drops.
- **Dirty hit, read:** way1 of set 2 is valid+dirty with tag matching `0x0000_1010`, data `0xAAAA0000`/`0xBBBB1111`; snoop `ccinv=0`, `dwait` low after 2 cycles per word. Required:
  - writes `{0x0000_1010, 0xAAAA0000}` then `{0x0000_1014, 0xBBBB1111}`;
  - then `st_wen` with idx=2, way=1, valid=1, dirty=0;
  - `cctrans` high 6 cycles.
- **Clean hit, invalidating:** way0 of set 5 valid+clean, `ccinv=1` -> no write-back; `st_wen` one cycle later with valid=0, dirty=0; `cctrans` high 2 cycles.
- **Dirty hit with `ccinv=1`:** both words written back, then state write valid=0, dirty=0.
- **Reset mid-WB1:** `RST` high for 1 cycle while `dwait=1` -> all outputs 0 on the next cycle and no `st_wen`. A following snoop of the same line repeats the full write-back.
- **Capture robustness:** `ccsnoopaddr` changes to a different set during WB0 -> the write-back address and data remain those captured at snoop start.

Source files
------------

// File: rtl/snoop_responder_if.sv
// Signal bundle between a dcache snoop responder, its cache arrays and the
// memory controller's snoop/memory ports.
interface snoop_responder_if #(
    parameter int SETS = 8,
    parameter int WAYS = 2
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                    ccwait;
    logic                    ccinv;
    logic [31:0]             ccsnoopaddr;
    logic                    dwait;
    logic                    cctrans;
    logic                    snp_active;
    logic                    snp_dWEN;
    logic [31:0]             snp_daddr;
    logic [31:0]             snp_dstore;
    logic [IDX_W-1:0]        tag_rd_idx;
    logic [WAYS*TAG_W-1:0]   way_tag;
    logic [WAYS-1:0]         way_valid;
    logic [WAYS-1:0]         way_dirty;
    logic [WAYS*32-1:0]      way_data0;
    logic [WAYS*32-1:0]      way_data1;
    logic                    st_wen;
    logic [IDX_W-1:0]        st_idx;
    logic [WAY_W-1:0]        st_way;
    logic                    st_valid;
    logic                    st_dirty;

    modport slave (
        input  ccwait, ccinv, ccsnoopaddr, dwait,
        input  way_tag, way_valid, way_dirty, way_data0, way_data1,
        output cctrans, snp_active, snp_dWEN, snp_daddr, snp_dstore,
        output tag_rd_idx, st_wen, st_idx, st_way, st_valid, st_dirty
    );

    modport master (
        output ccwait, ccinv, ccsnoopaddr, dwait,
        output way_tag, way_valid, way_dirty, way_data0, way_data1,
        input  cctrans, snp_active, snp_dWEN, snp_daddr, snp_dstore,
        input  tag_rd_idx, st_wen, st_idx, st_way, st_valid, st_dirty
    );
endinterface

// File: rtl/snoop_responder.sv
// Cache-side snoop responder: looks up a snooped block, writes back a dirty
// line over the dcache memory port, then demotes it to S (or I on invalidate).
module snoop_responder #(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic CLK,
    input  logic RST,
    snoop_responder_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB0    = 3'd1,
        WB1    = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic             hit_reg;
    logic [WAY_W-1:0] way_reg;
    logic             dirty_reg;
    logic [TAG_W-1:0] tag_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      data0_reg;
    logic [31:0]      data1_reg;
    logic             inv_reg;

    logic [TAG_W-1:0] snoop_tag;
    logic [WAYS-1:0]  hit_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic             hit_dirty;
    logic [31:0]      hit_data0;
    logic [31:0]      hit_data1;
    logic             capture_en;
    logic             unused_bits;

    assign snoop_tag      = bus.ccsnoopaddr[31:IDX_W+3];
    assign bus.tag_rd_idx = bus.ccsnoopaddr[IDX_W+2:3];
    assign capture_en     = (state_reg == IDLE) && bus.ccwait;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = bus.way_valid[gi] &&
                                 (bus.way_tag[gi*TAG_W +: TAG_W] == snoop_tag);
        end
    endgenerate

    // Scan from the top way down so the lowest hitting way is the one kept.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_dirty = bus.way_dirty[hit_way];
    assign hit_data0 = bus.way_data0[int'(hit_way)*32 +: 32];
    assign hit_data1 = bus.way_data1[int'(hit_way)*32 +: 32];

    // Everything needed later is frozen in the first ccwait cycle so address
    // or array changes during the write-back cannot corrupt it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_reg   <= 1'b0;
            way_reg   <= '0;
            dirty_reg <= 1'b0;
            tag_reg   <= '0;
            idx_reg   <= '0;
            data0_reg <= '0;
            data1_reg <= '0;
            inv_reg   <= 1'b0;
        end else if (capture_en) begin
            hit_reg   <= hit_any;
            way_reg   <= hit_way;
            dirty_reg <= hit_any && hit_dirty;
            tag_reg   <= snoop_tag;
            idx_reg   <= bus.tag_rd_idx;
            data0_reg <= hit_data0;
            data1_reg <= hit_data1;
            inv_reg   <= bus.ccinv;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ccwait) begin
                    if (hit_any && hit_dirty)     state_next = WB0;
                    else if (hit_any && bus.ccinv) state_next = UPDATE;
                    else                          state_next = DONE;
                end
            end
            WB0:     if (!bus.dwait) state_next = WB1;
            WB1:     if (!bus.dwait) state_next = UPDATE;
            UPDATE:  state_next = DONE;
            DONE:    if (!bus.ccwait) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cctrans    = 1'b0;
        bus.snp_active = 1'b0;
        bus.snp_dWEN   = 1'b0;
        bus.snp_daddr  = '0;
        bus.snp_dstore = '0;
        bus.st_wen     = 1'b0;
        bus.st_idx     = '0;
        bus.st_way     = '0;
        bus.st_valid   = 1'b0;
        bus.st_dirty   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Raised in the very first ccwait cycle so the controller
                // stays in its snoop state until the lookup has decided.
                bus.cctrans    = bus.ccwait;
                bus.snp_active = bus.ccwait;
            end
            WB0: begin
                bus.cctrans    = 1'b1;
                bus.snp_active = 1'b1;
                bus.snp_dWEN   = 1'b1;
                bus.snp_daddr  = {tag_reg, idx_reg, 1'b0, 2'b00};
                bus.snp_dstore = data0_reg;
            end
            WB1: begin
                bus.cctrans    = 1'b1;
                bus.snp_active = 1'b1;
                bus.snp_dWEN   = 1'b1;
                bus.snp_daddr  = {tag_reg, idx_reg, 1'b1, 2'b00};
                bus.snp_dstore = data1_reg;
            end
            UPDATE: begin
                bus.cctrans    = 1'b1;
                bus.snp_active = 1'b1;
                bus.st_wen     = 1'b1;
                bus.st_idx     = idx_reg;
                bus.st_way     = way_reg;
                bus.st_valid   = ~inv_reg;
                bus.st_dirty   = 1'b0;
            end
            DONE: begin
                bus.snp_active = 1'b1;
            end
            default: ;
        endcase
    end

    assign unused_bits = ^{bus.ccsnoopaddr[2:0], hit_reg, dirty_reg};

endmodule

// File: tb/tb_snoop_responder.sv
// Directed scoreboard bench for snoop_responder: expected write-backs and
// state writes are queued at stimulus time and matched as the DUT issues them.
module tb_snoop_responder;
    localparam int SETS  = 8;
    localparam int WAYS  = 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 3;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WAY_W-1:0] way;
        logic             valid;
        logic             dirty;
    } st_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    snoop_responder_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

    snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    logic [TAG_W-1:0] tags   [SETS][WAYS];
    logic             valids [SETS][WAYS];
    logic             dirtys [SETS][WAYS];
    logic [31:0]      d0s    [SETS][WAYS];
    logic [31:0]      d1s    [SETS][WAYS];

    always_comb begin
        bus.way_tag   = '0;
        bus.way_valid = '0;
        bus.way_dirty = '0;
        bus.way_data0 = '0;
        bus.way_data1 = '0;
        for (int w = 0; w < WAYS; w++) begin
            bus.way_tag[w*TAG_W +: TAG_W] = tags[bus.tag_rd_idx][w];
            bus.way_valid[w]              = valids[bus.tag_rd_idx][w];
            bus.way_dirty[w]              = dirtys[bus.tag_rd_idx][w];
            bus.way_data0[w*32 +: 32]     = d0s[bus.tag_rd_idx][w];
            bus.way_data1[w*32 +: 32]     = d1s[bus.tag_rd_idx][w];
        end
    end

    wb_t wb_q[$];
    st_t st_q[$];
    int  checks = 0;
    int  errors = 0;
    int  trans_cnt = 0;
    int  mem_hold = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return a[31:IDX_W+3];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] a);
        return a[IDX_W+2:3];
    endfunction

    // Memory port: holds dwait high for mem_hold cycles of each write word.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.dwait = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.snp_dWEN) begin
                if (wait_cnt < mem_hold) begin
                    bus.dwait = 1'b1;
                    wait_cnt++;
                end else begin
                    bus.dwait = 1'b0;
                    wait_cnt = 0;
                end
            end else begin
                bus.dwait = 1'b1;
                wait_cnt = 0;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge CLK) begin
        if (RST) begin
            prev_hold = 1'b0;
        end else begin
            wb_t w;
            st_t s;
            if (bus.cctrans) trans_cnt++;
            if (prev_hold) begin
                chk("wb_hold_wen", bus.snp_dWEN, 1'b1);
                chk("wb_hold_addr", bus.snp_daddr, prev_addr);
                chk("wb_hold_data", bus.snp_dstore, prev_data);
            end
            if (bus.snp_dWEN && !bus.dwait) begin
                $display("wb   addr=%h data=%h", bus.snp_daddr, bus.snp_dstore);
                chk("wb_expected", wb_q.size() > 0, 1'b1);
                if (wb_q.size() > 0) begin
                    w = wb_q.pop_front();
                    chk("wb_addr", bus.snp_daddr, w.addr);
                    chk("wb_data", bus.snp_dstore, w.data);
                end
            end
            if (bus.st_wen) begin
                $display("st   idx=%0d way=%0d valid=%0b dirty=%0b",
                         bus.st_idx, bus.st_way, bus.st_valid, bus.st_dirty);
                chk("st_expected", st_q.size() > 0, 1'b1);
                if (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    chk("st_payload", {bus.st_idx, bus.st_way, bus.st_valid, bus.st_dirty}, s);
                end
            end
            prev_hold = bus.snp_dWEN && bus.dwait;
            prev_addr = bus.snp_daddr;
            prev_data = bus.snp_dstore;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_line(input logic [31:0] a, input int way, input logic v,
                            input logic d, input logic [31:0] w0, input logic [31:0] w1);
        tags[idx_of(a)][way]   = tag_of(a);
        valids[idx_of(a)][way] = v;
        dirtys[idx_of(a)][way] = d;
        d0s[idx_of(a)][way]    = w0;
        d1s[idx_of(a)][way]    = w1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {bus.cctrans, bus.snp_active, bus.snp_dWEN, bus.st_wen,
                            bus.st_valid, bus.st_dirty}, 6'b0);
        chk({tag, "_daddr"}, bus.snp_daddr, 32'h0);
        chk({tag, "_dstore"}, bus.snp_dstore, 32'h0);
        chk({tag, "_st_loc"}, {bus.st_idx, bus.st_way}, '0);
    endtask

    task automatic snoop(input string tag, input logic [31:0] a, input logic inv,
                         input int hold, input int exp_cycles,
                         input bit do_switch, input logic [31:0] alt);
        bit done;
        bit switched;
        mem_hold  = hold;
        trans_cnt = 0;
        done      = 1'b0;
        switched  = 1'b0;
        bus.ccsnoopaddr = a;
        bus.ccinv       = inv;
        bus.ccwait      = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge CLK);
            #2;
            if (do_switch && !switched && bus.snp_dWEN) begin
                bus.ccsnoopaddr = alt;
                bus.ccinv       = ~inv;
                switched        = 1'b1;
            end
            if (bus.snp_active && !bus.cctrans) done = 1'b1;
        end
        chk({tag, "_reached_done"}, done, 1'b1);
        chk({tag, "_cctrans_cycles"}, trans_cnt, exp_cycles);
        bus.ccwait = 1'b0;
        @(posedge CLK);
        #2;
        chk({tag, "_released"}, {bus.cctrans, bus.snp_active}, 2'b00);
    endtask

    initial begin
        logic [31:0] a;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                tags[s][w] = '0; valids[s][w] = 1'b0; dirtys[s][w] = 1'b0;
                d0s[s][w] = '0;  d1s[s][w] = '0;
            end
        end
        bus.ccwait = 1'b0;
        bus.ccinv = 1'b0;
        bus.ccsnoopaddr = '0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        chk_quiet("reset");
        RST = 1'b0;
        @(posedge CLK);
        #2;
        chk_quiet("idle");

        // Miss: one cctrans cycle, then parked in DONE while ccwait stays high.
        mem_hold = 0;
        trans_cnt = 0;
        bus.ccsnoopaddr = 32'h0000_0040;
        bus.ccinv = 1'b0;
        bus.ccwait = 1'b1;
        repeat (4) @(posedge CLK);
        #2;
        chk("miss_done_hold", {bus.cctrans, bus.snp_active}, 2'b01);
        chk("miss_cctrans_cycles", trans_cnt, 1);
        bus.ccwait = 1'b0;
        @(posedge CLK);
        #2;
        chk("miss_released", bus.snp_active, 1'b0);

        // Dirty read hit in way1 of set 2; way0 holds an unrelated valid line.
        a = 32'h0000_1010;
        set_line(32'h0000_5010, 0, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        set_line(a, 1, 1'b1, 1'b1, 32'hAAAA_0000, 32'hBBBB_1111);
        wb_q.push_back('{addr: 32'h0000_1010, data: 32'hAAAA_0000});
        wb_q.push_back('{addr: 32'h0000_1014, data: 32'hBBBB_1111});
        st_q.push_back('{idx: 3'd2, way: 1'b1, valid: 1'b1, dirty: 1'b0});
        snoop("dirty_read", a, 1'b0, 1, 6, 1'b0, 32'h0);

        // Clean invalidating hit in way0 of set 5.
        a = 32'h0000_2028;
        set_line(a, 0, 1'b1, 1'b0, 32'hCCCC_0000, 32'hDDDD_0000);
        st_q.push_back('{idx: 3'd5, way: 1'b0, valid: 1'b0, dirty: 1'b0});
        snoop("clean_inv", a, 1'b1, 0, 2, 1'b0, 32'h0);

        // Clean read hit leaves the line alone.
        snoop("clean_read", a, 1'b0, 0, 1, 1'b0, 32'h0);

        // Dirty invalidating hit.
        a = 32'h0000_1010;
        set_line(a, 1, 1'b1, 1'b1, 32'h5555_0000, 32'h6666_0000);
        wb_q.push_back('{addr: 32'h0000_1010, data: 32'h5555_0000});
        wb_q.push_back('{addr: 32'h0000_1014, data: 32'h6666_0000});
        st_q.push_back('{idx: 3'd2, way: 1'b1, valid: 1'b0, dirty: 1'b0});
        snoop("dirty_inv", a, 1'b1, 0, 4, 1'b0, 32'h0);

        // Both ways of set 3 hit: the lower way is the one written back.
        a = 32'h0000_1018;
        set_line(a, 0, 1'b1, 1'b1, 32'h1111_0000, 32'h1111_0001);
        set_line(a, 1, 1'b1, 1'b1, 32'h2222_0000, 32'h2222_0001);
        wb_q.push_back('{addr: 32'h0000_1018, data: 32'h1111_0000});
        wb_q.push_back('{addr: 32'h0000_101C, data: 32'h1111_0001});
        st_q.push_back('{idx: 3'd3, way: 1'b0, valid: 1'b1, dirty: 1'b0});
        snoop("two_way_hit", a, 1'b0, 0, 4, 1'b0, 32'h0);

        // Reset while WB1 is stalled: only word 0 ever completes.
        a = 32'h0000_1010;
        set_line(a, 1, 1'b1, 1'b1, 32'h7777_0000, 32'h8888_0000);
        wb_q.push_back('{addr: 32'h0000_1010, data: 32'h7777_0000});
        mem_hold = 5;
        bus.ccsnoopaddr = a;
        bus.ccinv = 1'b0;
        bus.ccwait = 1'b1;
        begin
            bit in_wb1;
            in_wb1 = 1'b0;
            for (int n = 0; n < 100 && !in_wb1; n++) begin
                @(posedge CLK);
                #2;
                if (bus.snp_dWEN && bus.snp_daddr[2] && bus.dwait) in_wb1 = 1'b1;
            end
            chk("rst_reached_wb1", in_wb1, 1'b1);
        end
        RST = 1'b1;
        bus.ccwait = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        chk_quiet("rst_mid_wb1");
        chk("rst_wb_pending", wb_q.size(), 0);
        @(posedge CLK);
        #2;
        wb_q.push_back('{addr: 32'h0000_1010, data: 32'h7777_0000});
        wb_q.push_back('{addr: 32'h0000_1014, data: 32'h8888_0000});
        st_q.push_back('{idx: 3'd2, way: 1'b1, valid: 1'b1, dirty: 1'b0});
        snoop("after_rst", a, 1'b0, 0, 4, 1'b0, 32'h0);

        // Address moves to set 6 during WB0; captured block must be used.
        set_line(a, 1, 1'b1, 1'b1, 32'h9999_0000, 32'hAAAA_9999);
        set_line(32'h0000_1030, 1, 1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0001);
        wb_q.push_back('{addr: 32'h0000_1010, data: 32'h9999_0000});
        wb_q.push_back('{addr: 32'h0000_1014, data: 32'hAAAA_9999});
        st_q.push_back('{idx: 3'd2, way: 1'b1, valid: 1'b1, dirty: 1'b0});
        snoop("capture", a, 1'b0, 2, 8, 1'b1, 32'h0000_1030);

        repeat (2) @(posedge CLK);
        #2;
        chk("final_wb_queue_empty", wb_q.size(), 0);
        chk("final_st_queue_empty", st_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
